// File: rtl/l2_banked_mem.sv
// Parametrised banked L2 SRAM wrapper: NB_BANKS banks of DATA_WIDTH/32 cuts each, REQ/GNT/RVALID
// handshake and a zero-fill sequencer. Optional macro L2_OUT_REG_EN adds an output register stage.

module l2_banked_mem_cut #(
  parameter int ADDR_WIDTH = 13
) (
  input  logic                  CLK,
  input  logic                  INITN,
  input  logic                  CEN,
  input  logic                  WEN,
  input  logic [ADDR_WIDTH-1:0] A,
  input  logic [31:0]           D,
  input  logic [3:0]            BEN,
  output logic [31:0]           Q
);
  logic [31:0] mem [2**ADDR_WIDTH];

  // Q only changes on a read, so it holds the last read word across writes.
  always_ff @(posedge CLK) begin
    if (INITN && !CEN) begin
      if (!WEN) begin
        for (int i = 0; i < 4; i++)
          if (!BEN[i]) mem[A][8*i +: 8] <= D[8*i +: 8];
      end else begin
        Q <= mem[A];
      end
    end
  end
endmodule

module l2_banked_mem #(
  parameter int DATA_WIDTH      = 64,
  parameter int BANK_ADDR_WIDTH = 13,
  parameter int NB_BANKS        = 4,
  parameter int CLEAR_ON_RESET  = 0,
  localparam int ADDR_WIDTH     = BANK_ADDR_WIDTH + $clog2(NB_BANKS)
) (
  input  logic                    CLK,
  input  logic                    RSTN,
  input  logic                    INITN,
  input  logic                    REQ,
  output logic                    GNT,
  input  logic                    WEN,
  input  logic [ADDR_WIDTH-1:0]   A,
  input  logic [DATA_WIDTH-1:0]   D,
  input  logic [DATA_WIDTH/8-1:0] BE,
  output logic                    RVALID,
  output logic [DATA_WIDTH-1:0]   Q,
  input  logic                    CLR_REQ,
  output logic                    BUSY,
  output logic                    CLR_DONE
);
  localparam int NB_CUTS = DATA_WIDTH / 32;
  localparam int SEL_W   = (NB_BANKS > 1) ? $clog2(NB_BANKS) : 1;

  if (DATA_WIDTH % 32 != 0) begin : g_err_width
    $error("l2_banked_mem: DATA_WIDTH must be a multiple of 32");
  end
  if (NB_BANKS < 1 || (NB_BANKS & (NB_BANKS - 1)) != 0) begin : g_err_banks
    $error("l2_banked_mem: NB_BANKS must be a power of 2");
  end

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t                         state, state_next;
  logic [BANK_ADDR_WIDTH-1:0]     row;
  logic                           boot;
  logic                           clearing;
  logic [SEL_W-1:0]               bank_sel;
  logic [SEL_W-1:0]               bank_p0;
  logic                           vld_p0;
  logic [DATA_WIDTH-1:0]          rdata_p0;
  logic                           cut_wen;
  logic [BANK_ADDR_WIDTH-1:0]     cut_a;
  logic [DATA_WIDTH-1:0]          cut_d;
  logic [DATA_WIDTH/8-1:0]        cut_ben;
  logic [NB_BANKS-1:0]            cut_cen;
  logic [NB_BANKS-1:0][DATA_WIDTH-1:0] bank_q;

  if (NB_BANKS > 1) begin : g_sel
    assign bank_sel = A[ADDR_WIDTH-1:BANK_ADDR_WIDTH];
  end else begin : g_nosel
    assign bank_sel = '0;
  end

  // boot forces one pass through CLEAR right after reset when CLEAR_ON_RESET is set.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state <= IDLE;
      row   <= '0;
      boot  <= (CLEAR_ON_RESET != 0);
    end else begin
      state <= state_next;
      boot  <= 1'b0;
      row   <= clearing ? row + BANK_ADDR_WIDTH'(1) : '0;
    end
  end

  always_comb begin
    state_next = state;
    CLR_DONE   = 1'b0;
    case (state)
      IDLE:  if (CLR_REQ || boot) state_next = CLEAR;
      CLEAR: if (row == '1) begin
        state_next = IDLE;
        CLR_DONE   = 1'b1;
      end
    endcase
  end

  assign clearing = (state == CLEAR);
  assign BUSY     = clearing;
  assign GNT      = REQ & RSTN & (state == IDLE) & ~CLR_REQ & ~boot;

  // During clear every cut of every bank writes zero to the current row.
  always_comb begin
    cut_wen = clearing ? 1'b0 : WEN;
    cut_a   = clearing ? row : A[BANK_ADDR_WIDTH-1:0];
    cut_d   = clearing ? '0 : D;
    cut_ben = clearing ? '0 : ~BE;
    for (int b = 0; b < NB_BANKS; b++)
      cut_cen[b] = ~(clearing | (GNT & (bank_sel == SEL_W'(b))));
  end

  for (genvar b = 0; b < NB_BANKS; b++) begin : g_bank
    for (genvar k = 0; k < NB_CUTS; k++) begin : g_cut
      l2_banked_mem_cut #(.ADDR_WIDTH(BANK_ADDR_WIDTH)) u_cut (
        .CLK   (CLK),
        .INITN (INITN),
        .CEN   (cut_cen[b]),
        .WEN   (cut_wen),
        .A     (cut_a),
        .D     (cut_d[32*k +: 32]),
        .BEN   (cut_ben[4*k +: 4]),
        .Q     (bank_q[b][32*k +: 32])
      );
    end
  end

  // Stage p0: cut outputs valid, bank of the accepted read selects the word.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) vld_p0 <= 1'b0;
    else       vld_p0 <= GNT & WEN;
  end

  always_ff @(posedge CLK) begin
    if (GNT) bank_p0 <= bank_sel;
  end

  assign rdata_p0 = bank_q[bank_p0];

`ifdef L2_OUT_REG_EN
  logic                  vld_p1;
  logic [DATA_WIDTH-1:0] q_p1;

  // Stage p1: registered output, held between reads.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      vld_p1 <= 1'b0;
      q_p1   <= '0;
    end else begin
      vld_p1 <= vld_p0;
      if (vld_p0) q_p1 <= rdata_p0;
    end
  end

  assign RVALID = vld_p1;
  assign Q      = q_p1;
`else
  assign RVALID = vld_p0;
  assign Q      = vld_p0 ? rdata_p0 : '0;
`endif
endmodule
